// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shifter_stage.sv
// One registered step of the barrel shifter: shifts by 2^K when shamt bit K is set.
// The whole request (valid, data, shamt, op, sign) moves forward only when en_i is high.
module shifter_stage
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [N-1:0]           data_i,
  input  logic [$clog2(N)-1:0]   shamt_i,
  input  shift_op_t              op_i,
  input  logic                   sign_i,
  output logic                   valid_o,
  output logic [N-1:0]           data_o,
  output logic [$clog2(N)-1:0]   shamt_o,
  output shift_op_t              op_o,
  output logic                   sign_o
);

  localparam int L = $clog2(N);
  localparam int S = 1 << K;

  logic          valid_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  data_d;
  logic [L-1:0]  shamt_q;
  shift_op_t     op_q;
  logic          sign_q;

  // SRA fills from the sign captured at entry, since earlier stages may already have moved the MSB.
  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      unique case (op_i)
        SHIFT_SLL: data_d = data_i << S;
        SHIFT_SRL: data_d = data_i >> S;
        SHIFT_SRA: data_d = {{S{sign_i}}, data_i[N-1:S]};
        SHIFT_ROR: data_d = {data_i[S-1:0], data_i[N-1:S]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= SHIFT_SLL;
      sign_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      op_q    <= op_i;
      sign_q  <= sign_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one register stage per shift-amount bit,
// with an elastic valid/ready pipeline whose ready is a combinational chain from out_ready.
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [L-1:0]  in_shamt,
  input  shift_op_t     in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_width
    $error("pipelined_barrel_shifter: N must be a power of two and at least 4");
  end

  logic          valid [L];
  logic [N-1:0]  data  [L];
  logic [L-1:0]  shamt [L];
  shift_op_t     op    [L];
  logic          sign  [L];
  logic          rdy   [L];
  logic          readyAcc;

  // A stage may advance if anything downstream will make room, or if it holds nothing.
  always_comb begin
    readyAcc = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      readyAcc = readyAcc || !valid[k];
      rdy[k]   = readyAcc;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic          validIn;
    logic [N-1:0]  dataIn;
    logic [L-1:0]  shamtIn;
    shift_op_t     opIn;
    logic          signIn;

    if (k == 0) begin : g_first
      assign validIn = in_valid;
      assign dataIn  = in_data;
      assign shamtIn = in_shamt;
      assign opIn    = in_op;
      assign signIn  = in_data[N-1];
    end else begin : g_next
      assign validIn = valid[k-1];
      assign dataIn  = data[k-1];
      assign shamtIn = shamt[k-1];
      assign opIn    = op[k-1];
      assign signIn  = sign[k-1];
    end

    shifter_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (rdy[k]),
      .valid_i (validIn),
      .data_i  (dataIn),
      .shamt_i (shamtIn),
      .op_i    (opIn),
      .sign_i  (signIn),
      .valid_o (valid[k]),
      .data_o  (data[k]),
      .shamt_o (shamt[k]),
      .op_o    (op[k]),
      .sign_o  (sign[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid[L-1];
  assign out_data  = data[L-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed corner cases, a random stream
// against a behavioural model, backpressure, reset flush, and an 8-bit instance.
module tb_pipelined_barrel_shifter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, outValid, outReady;
  logic [31:0] inData, outData;
  logic [4:0]  inShamt;
  shift_op_t   inOp;

  logic        in8Valid, in8Ready, out8Valid, out8Ready;
  logic [7:0]  in8Data, out8Data;
  logic [2:0]  in8Shamt;
  shift_op_t   in8Op;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ [$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(32)) dut (
    .clk (clk), .rst (rst),
    .in_valid (inValid), .in_ready (inReady), .in_data (inData),
    .in_shamt (inShamt), .in_op (inOp),
    .out_valid (outValid), .out_ready (outReady), .out_data (outData)
  );

  pipelined_barrel_shifter #(.N(8)) dut8 (
    .clk (clk), .rst (rst),
    .in_valid (in8Valid), .in_ready (in8Ready), .in_data (in8Data),
    .in_shamt (in8Shamt), .in_op (in8Op),
    .out_valid (out8Valid), .out_ready (out8Ready), .out_data (out8Data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: shift semantics written directly as arithmetic on a w-bit word.
  function automatic logic [63:0] refShift(input int w, input logic [63:0] d, input int s, input shift_op_t op);
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    d = d & mask;
    case (op)
      SHIFT_SLL: r = (d << s) & mask;
      SHIFT_SRL: r = d >> s;
      SHIFT_SRA: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      default:   r = ((d >> s) | (d << (w - s))) & mask;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] s, input shift_op_t op);
    inValid = v;
    inData  = d;
    inShamt = s;
    inOp    = op;
  endtask

  task automatic stepCycle(output bit acc, output bit ir, output bit ov, output logic [31:0] od);
    @(negedge clk);
    ir  = inReady;
    ov  = outValid;
    od  = outData;
    acc = inValid && inReady;
    if (outValid && outReady) begin
      if (expQ.size() == 0) checkOutput("spurious result", 64'(outValid), 64'd0);
      else checkOutput("stream result", 64'(outData), expQ.pop_front());
    end
    if (acc) expQ.push_back(refShift(32, 64'(inData), int'(inShamt), inOp));
    @(posedge clk); #1;
  endtask

  task automatic runOne(input string tag, input logic [31:0] d, input logic [4:0] s, input shift_op_t op, input logic [31:0] expected);
    int edges;
    outReady = 1'b1;
    applyStimulus(1'b1, d, s, op);
    #3;
    checkOutput({tag, " accept"}, 64'(inReady), 64'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, d, s, op);
    edges = 1;
    while (!outValid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, " latency"}, 64'(edges), 64'd5);
    checkOutput({tag, " data"}, 64'(outData), 64'(expected));
    @(posedge clk); #1;
  endtask

  task automatic runOne8(input string tag, input logic [7:0] d, input logic [2:0] s, input shift_op_t op, input logic [7:0] expected);
    int edges;
    out8Ready = 1'b1;
    in8Valid = 1'b1; in8Data = d; in8Shamt = s; in8Op = op;
    #3;
    checkOutput({tag, " accept"}, 64'(in8Ready), 64'd1);
    @(posedge clk); #1;
    in8Valid = 1'b0;
    edges = 1;
    while (!out8Valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, " latency"}, 64'(edges), 64'd3);
    checkOutput({tag, " data"}, 64'(out8Data), 64'(expected));
    @(posedge clk); #1;
  endtask

  initial begin
    bit          acc, ir, ov, allReady, haveHeld, sawValid;
    logic [31:0] od, heldData;
    int          drains, reqIdx;
    logic [31:0] reqData [7];
    logic [4:0]  reqShamt [7];
    shift_op_t   reqOp [7];

    rst = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, SHIFT_SLL);
    in8Valid = 1'b0; in8Data = 8'h0; in8Shamt = 3'd0; in8Op = SHIFT_SLL; out8Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset in_ready", 64'(inReady), 64'd1);
    checkOutput("reset out_data", 64'(outData), 64'd0);
    checkOutput("reset8 out_valid", 64'(out8Valid), 64'd0);
    checkOutput("reset8 in_ready", 64'(in8Ready), 64'd1);

    $display("[TB] directed corner cases");
    runOne("sra msb 31", 32'h8000_0000, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF);
    runOne("sra pos 4", 32'h7FFF_FFF0, 5'd4, SHIFT_SRA, 32'h07FF_FFFF);
    runOne("srl 4", 32'h8000_0000, 5'd4, SHIFT_SRL, 32'h0800_0000);
    runOne("sll 31", 32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000);
    runOne("ror 1", 32'h0000_0001, 5'd1, SHIFT_ROR, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      od = $urandom | 32'h8000_0001;
      runOne("shamt0", od, 5'd0, shift_op_t'(2'(i)), od);
    end

    $display("[TB] random back-to-back stream");
    allReady = 1'b1;
    drains = 0;
    outReady = 1'b1;
    for (int c = 0; c < 105; c++) begin
      if (c < 100) applyStimulus(1'b1, $urandom, 5'($urandom_range(0, 31)), shift_op_t'(2'($urandom_range(0, 3))));
      else applyStimulus(1'b0, 32'h0, 5'd0, SHIFT_SLL);
      stepCycle(acc, ir, ov, od);
      if (c < 100 && !ir) allReady = 1'b0;
      if (ov) drains++;
    end
    checkOutput("stream in_ready high", 64'(allReady), 64'd1);
    checkOutput("stream result count", 64'(drains), 64'd100);
    checkOutput("stream queue empty", 64'(expQ.size()), 64'd0);

    $display("[TB] backpressure");
    for (int i = 0; i < 7; i++) begin
      reqData[i]  = $urandom;
      reqShamt[i] = 5'($urandom_range(0, 31));
      reqOp[i]    = shift_op_t'(2'($urandom_range(0, 3)));
    end
    outReady = 1'b0;
    reqIdx = 0;
    haveHeld = 1'b0;
    heldData = 32'h0;
    ir = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, reqData[reqIdx], reqShamt[reqIdx], reqOp[reqIdx]);
      stepCycle(acc, ir, ov, od);
      if (acc) reqIdx++;
      if (ov) begin
        if (haveHeld) checkOutput("stall data stable", 64'(od), 64'(heldData));
        else begin
          heldData = od;
          haveHeld = 1'b1;
        end
      end
    end
    checkOutput("stall accepted count", 64'(reqIdx), 64'd5);
    checkOutput("full in_ready", 64'(ir), 64'd0);
    checkOutput("full out_valid seen", 64'(haveHeld), 64'd1);
    outReady = 1'b1;
    for (int c = 0; c < 30 && !(reqIdx == 7 && expQ.size() == 0); c++) begin
      if (reqIdx < 7) applyStimulus(1'b1, reqData[reqIdx], reqShamt[reqIdx], reqOp[reqIdx]);
      else applyStimulus(1'b0, 32'h0, 5'd0, SHIFT_SLL);
      stepCycle(acc, ir, ov, od);
      if (acc) reqIdx++;
    end
    applyStimulus(1'b0, 32'h0, 5'd0, SHIFT_SLL);
    checkOutput("release accepted all", 64'(reqIdx), 64'd7);
    checkOutput("release drained all", 64'(expQ.size()), 64'd0);

    $display("[TB] reset flush");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hFFFF_0000 + 32'(i), 5'(i + 1), SHIFT_ROR);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678, 5'd3, SHIFT_SLL);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, SHIFT_SLL);
    checkOutput("flush out_valid", 64'(outValid), 64'd0);
    checkOutput("flush out_data", 64'(outData), 64'd0);
    checkOutput("flush in_ready", 64'(inReady), 64'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("flush no stale result", 64'(sawValid), 64'd0);
    runOne("after reset", 32'hC000_0003, 5'd2, SHIFT_ROR, 32'hF000_0000);

    $display("[TB] 8-bit instance");
    runOne8("n8 sra 3", 8'h90, 3'd3, SHIFT_SRA, 8'hF2);
    runOne8("n8 ror 7", 8'h81, 3'd7, SHIFT_ROR, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
